// File: rtl/lesson_sequencer.sv
// Lesson-mode sequencer: walks the player through the Ode to Joy phrase,
// lights the LED of the expected key, judges debounced presses, counts
// mistakes and blinks a hint after a period without a press.
//
// state          | meaning
// ---------------+--------------------------------------------------
// S_IDLE         | no lesson running, LEDs dark, waiting for START
// S_WAIT_PRESS   | guide LED lit (may blink as a hint), next press judged
// S_WAIT_RELEASE | press judged, waiting for all keys released
// S_DONE         | phrase finished, all LEDs lit until START/RESET
module lesson_sequencer #(
  parameter int SONG_LEN   = 15,
  parameter int HINT_TICKS = 8,
  parameter int MISS_W     = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              TICK,
  input  logic [3:0]        note,
  output logic [7:0]        Led,
  output logic [3:0]        expect_note,
  output logic [3:0]        index,
  output logic [MISS_W-1:0] mistakes,
  output logic              correct,
  output logic              wrong,
  output logic              done
);

  localparam logic [1:0] S_IDLE         = 2'd0;
  localparam logic [1:0] S_WAIT_PRESS   = 2'd1;
  localparam logic [1:0] S_WAIT_RELEASE = 2'd2;
  localparam logic [1:0] S_DONE         = 2'd3;

  localparam logic [3:0]        LAST_IDX = 4'(SONG_LEN - 1);
  localparam logic [7:0]        HINT_MAX = 8'(HINT_TICKS);
  localparam logic [MISS_W-1:0] MISS_MAX = {MISS_W{1'b1}};

  logic [1:0]        state_q,   state_d;
  logic [3:0]        index_q,   index_d;
  logic [MISS_W-1:0] miss_q,    miss_d;
  logic [7:0]        hint_q,    hint_d;
  logic              blink_q,   blink_d;
  logic              adv_q,     adv_d;
  logic              correct_q, correct_d;
  logic              wrong_q,   wrong_d;

  logic [3:0] note_v;
  logic [3:0] cur_code;
  logic [7:0] cur_led;

  function automatic logic [3:0] rom_code(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0, 4'd1, 4'd6, 4'd11, 4'd12: code = 4'd3;
      4'd2, 4'd5:                     code = 4'd4;
      4'd3, 4'd4:                     code = 4'd5;
      4'd7, 4'd10, 4'd13, 4'd14:      code = 4'd2;
      4'd8, 4'd9:                     code = 4'd1;
      default:                        code = 4'd0;
    endcase
    return code;
  endfunction

  // Code k lights bit (8-k) so the LED order follows the switch order.
  function automatic logic [7:0] key_onehot(input logic [3:0] code);
    logic [7:0] led;
    case (code)
      4'd1:    led = 8'b1000_0000;
      4'd2:    led = 8'b0100_0000;
      4'd3:    led = 8'b0010_0000;
      4'd4:    led = 8'b0001_0000;
      4'd5:    led = 8'b0000_1000;
      4'd6:    led = 8'b0000_0100;
      4'd7:    led = 8'b0000_0010;
      4'd8:    led = 8'b0000_0001;
      default: led = 8'b0000_0000;
    endcase
    return led;
  endfunction

  assign note_v   = (note >= 4'd1 && note <= 4'd8) ? note : 4'd0;
  assign cur_code = rom_code(index_q);
  assign cur_led  = key_onehot(cur_code);

  // Next-state logic: START overrides every other event in the same cycle.
  always_comb begin
    state_d   = state_q;
    index_d   = index_q;
    miss_d    = miss_q;
    hint_d    = hint_q;
    blink_d   = blink_q;
    adv_d     = adv_q;
    correct_d = 1'b0;
    wrong_d   = 1'b0;
    if (START) begin
      state_d = S_WAIT_PRESS;
      index_d = 4'd0;
      miss_d  = '0;
      hint_d  = 8'd0;
      blink_d = 1'b0;
      adv_d   = 1'b0;
    end else begin
      case (state_q)
        S_WAIT_PRESS: begin
          if (note_v != 4'd0) begin
            if (note_v == cur_code) begin
              correct_d = 1'b1;
              adv_d     = 1'b1;
            end else begin
              wrong_d = 1'b1;
              adv_d   = 1'b0;
              if (miss_q != MISS_MAX) miss_d = miss_q + MISS_W'(1);
            end
            state_d = S_WAIT_RELEASE;
          end else if (TICK) begin
            hint_d = (hint_q == HINT_MAX) ? hint_q : hint_q + 8'd1;
            // Blinking starts on the tick that reaches the threshold, so the
            // LED stays lit on that tick and goes dark on the following one.
            if (hint_d == HINT_MAX) blink_d = ~blink_q;
          end
        end
        S_WAIT_RELEASE: begin
          if (note_v == 4'd0) begin
            hint_d  = 8'd0;
            blink_d = 1'b0;
            if (adv_q && index_q == LAST_IDX) begin
              state_d = S_DONE;
            end else begin
              if (adv_q) index_d = index_q + 4'd1;
              state_d = S_WAIT_PRESS;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State and pulse registers, cleared asynchronously on RESET.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      index_q   <= 4'd0;
      miss_q    <= '0;
      hint_q    <= 8'd0;
      blink_q   <= 1'b0;
      adv_q     <= 1'b0;
      correct_q <= 1'b0;
      wrong_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      miss_q    <= miss_d;
      hint_q    <= hint_d;
      blink_q   <= blink_d;
      adv_q     <= adv_d;
      correct_q <= correct_d;
      wrong_q   <= wrong_d;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    Led         = 8'h00;
    expect_note = 4'd0;
    case (state_q)
      S_WAIT_PRESS: begin
        expect_note = cur_code;
        if (hint_q == HINT_MAX) Led = blink_q ? cur_led : 8'h00;
        else                    Led = cur_led;
      end
      S_WAIT_RELEASE: begin
        expect_note = cur_code;
        Led         = cur_led;
      end
      S_DONE:  Led = 8'hFF;
      default: ;
    endcase
  end

  assign index    = index_q;
  assign mistakes = miss_q;
  assign correct  = correct_q;
  assign wrong    = wrong_q;
  assign done     = (state_q == S_DONE);

endmodule
